// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch controller: walks a PC through instruction memory,
// registers each fetched word with its PC+4, honours stall and branch
// redirects, and halts once the PC runs past the last valid word.
//
// Ports
//   i_clk               clock, all state updates on the rising edge
//   i_reset             synchronous active-high reset
//   i_start             begin fetching (only looked at while idle)
//   i_stall             hold PC and fetch outputs this cycle
//   i_branch_taken      redirect fetch to i_branch_target this cycle
//   i_branch_target     redirect byte address (low two bits dropped)
//   i_imem_instruction  combinational read data at o_imem_address
//   o_imem_address      memory read address, equal to the PC register
//   o_pc_result         current PC register
//   o_instr_out         registered fetched instruction
//   o_pc_plus4_out      registered address of o_instr_out plus 4
//   o_instr_valid       o_instr_out / o_pc_plus4_out hold a valid fetch
//   o_halted            fetch stopped at end of program space
module instruction_fetch_ctrl #(
    parameter logic [31:0] LAST_ADDR = 32'h000001FC,
    parameter logic [31:0] RESET_PC  = 32'h00000000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_stall,
    input  logic        i_branch_taken,
    input  logic [31:0] i_branch_target,
    input  logic [31:0] i_imem_instruction,
    output logic [31:0] o_imem_address,
    output logic [31:0] o_pc_result,
    output logic [31:0] o_instr_out,
    output logic [31:0] o_pc_plus4_out,
    output logic        o_instr_valid,
    output logic        o_halted
);

    localparam int unsigned AW = 32;
    localparam logic [AW-1:0] WORD_MASK = ~AW'(3);
    localparam logic [AW-1:0] PC_INIT   = RESET_PC & WORD_MASK;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_instr;
    logic [AW-1:0] r_pc_plus4;
    logic          r_valid;
    logic          r_halted;

    state_t        w_state_nxt;
    logic [AW-1:0] w_pc_nxt;
    logic [AW-1:0] w_instr_nxt;
    logic [AW-1:0] w_pc_plus4_nxt;
    logic          w_valid_nxt;
    logic          w_halted_nxt;
    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_branch_pc;

    // Word-aligned arithmetic; wraps modulo 2^32.
    assign w_pc_inc    = r_pc + AW'(4);
    assign w_branch_pc = i_branch_target & WORD_MASK;

    // State and datapath registers.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= S_IDLE;
            r_pc       <= PC_INIT;
            r_instr    <= '0;
            r_pc_plus4 <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_instr    <= w_instr_nxt;
            r_pc_plus4 <= w_pc_plus4_nxt;
            r_valid    <= w_valid_nxt;
            r_halted   <= w_halted_nxt;
        end
    end

    // Next-state and next-datapath logic; everything holds unless changed.
    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_instr_nxt    = r_instr;
        w_pc_plus4_nxt = r_pc_plus4;
        w_valid_nxt    = r_valid;
        w_halted_nxt   = r_halted;

        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Branch beats both the end-of-program check and stall.
                if (i_branch_taken) begin
                    w_pc_nxt       = w_branch_pc;
                    w_instr_nxt    = '0;
                    w_pc_plus4_nxt = '0;
                    w_valid_nxt    = 1'b0;
                end else if (r_pc > LAST_ADDR) begin
                    w_state_nxt  = S_HALT;
                    w_halted_nxt = 1'b1;
                    w_valid_nxt  = 1'b0;
                end else if (!i_stall) begin
                    w_instr_nxt    = i_imem_instruction;
                    w_pc_plus4_nxt = w_pc_inc;
                    w_pc_nxt       = w_pc_inc;
                    w_valid_nxt    = 1'b1;
                end
            end
            S_HALT: begin
                w_halted_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign o_imem_address = r_pc;
    assign o_pc_result    = r_pc;
    assign o_instr_out    = r_instr;
    assign o_pc_plus4_out = r_pc_plus4;
    assign o_instr_valid  = r_valid;
    assign o_halted       = r_halted;

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: a directed vector table, a free-run
// to end-of-program sequence, and randomized traffic against a reference
// model. Memory word i holds the value i.
module tb_instruction_fetch_ctrl;

    localparam logic [31:0] LAST = 32'h000001FC;

    logic        clk = 1'b0;
    logic        reset, start, stall, br;
    logic [31:0] tgt;
    logic [31:0] imem_addr, imem_data, pc, instr, pc4;
    logic        valid, halted;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    assign imem_data = mem_word(imem_addr);

    instruction_fetch_ctrl #(.LAST_ADDR(LAST), .RESET_PC(32'h0)) dut (
        .i_clk              (clk),
        .i_reset            (reset),
        .i_start            (start),
        .i_stall            (stall),
        .i_branch_taken     (br),
        .i_branch_target    (tgt),
        .i_imem_instruction (imem_data),
        .o_imem_address     (imem_addr),
        .o_pc_result        (pc),
        .o_instr_out        (instr),
        .o_pc_plus4_out     (pc4),
        .o_instr_valid      (valid),
        .o_halted           (halted)
    );

    // Reference model: fetch-pipeline contents plus "started"/"halted" flags.
    logic [31:0] m_pc, m_ins, m_p4;
    bit          m_v, m_h, m_run;

    task automatic model_step(input bit r, input bit s, input bit sl,
                              input bit b, input logic [31:0] t);
        if (r) begin
            m_pc = 0; m_ins = 0; m_p4 = 0; m_v = 0; m_h = 0; m_run = 0;
        end else if (m_h) begin
            // frozen until reset
        end else if (!m_run) begin
            if (s) m_run = 1;
        end else if (b) begin
            m_pc = {t[31:2], 2'b00}; m_ins = 0; m_p4 = 0; m_v = 0;
        end else if (m_pc > LAST) begin
            m_h = 1; m_v = 0;
        end else if (!sl) begin
            m_ins = mem_word(m_pc);
            m_p4  = m_pc + 32'd4;
            m_pc  = m_pc + 32'd4;
            m_v   = 1;
        end
    endtask

    // One clock: drive on the falling edge, sample 1 ns after the rising edge.
    task automatic cyc(input bit r, input bit s, input bit sl,
                       input bit b, input logic [31:0] t);
        @(negedge clk);
        reset = r; start = s; stall = sl; br = b; tgt = t;
        model_step(r, s, sl, b, t);
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] e_pc, input logic [31:0] e_ins,
                           input logic [31:0] e_p4, input bit e_v, input bit e_h);
        chk({tag, ".pc"},     pc,        e_pc);
        chk({tag, ".imem"},   imem_addr, e_pc);
        chk({tag, ".instr"},  instr,     e_ins);
        chk({tag, ".pc4"},    pc4,       e_p4);
        chk({tag, ".valid"},  32'(valid),  32'(e_v));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
    endtask

    typedef struct {
        bit          rst, st, sl, br;
        logic [31:0] tgt;
        logic [31:0] e_pc, e_ins, e_p4;
        bit          e_v, e_h;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit rs, input bit st, input bit sl, input bit b,
                       input logic [31:0] t, input logic [31:0] ep,
                       input logic [31:0] ei, input logic [31:0] e4,
                       input bit ev, input bit eh);
        vec_t v;
        v.rst = rs; v.st = st; v.sl = sl; v.br = b; v.tgt = t;
        v.e_pc = ep; v.e_ins = ei; v.e_p4 = e4; v.e_v = ev; v.e_h = eh;
        tbl.push_back(v);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0;

        //  rst st sl br  tgt        pc        instr  pc4       v  h
        add(1, 0, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // reset
        add(0, 0, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // idle holds
        add(0, 1, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // start, PC unchanged
        add(0, 0, 0, 0, 32'h0,   32'h004, 0,   32'h004, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h008, 1,   32'h008, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h00C, 2,   32'h00C, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h010, 3,   32'h010, 1, 0);
        add(0, 0, 1, 0, 32'h0,   32'h010, 3,   32'h010, 1, 0);  // stall x3
        add(0, 0, 1, 0, 32'h0,   32'h010, 3,   32'h010, 1, 0);
        add(0, 0, 1, 0, 32'h0,   32'h010, 3,   32'h010, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h014, 4,   32'h014, 1, 0);  // resumes with word 4
        add(0, 0, 0, 0, 32'h0,   32'h018, 5,   32'h018, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h01C, 6,   32'h01C, 1, 0);
        add(0, 0, 0, 0, 32'h0,   32'h020, 7,   32'h020, 1, 0);
        add(0, 0, 0, 1, 32'h103, 32'h100, 0,   32'h000, 0, 0);  // branch, low bits dropped
        add(0, 0, 0, 0, 32'h0,   32'h104, 64,  32'h104, 1, 0);
        add(0, 0, 1, 1, 32'h40,  32'h040, 0,   32'h000, 0, 0);  // branch beats stall
        add(0, 0, 1, 0, 32'h0,   32'h040, 0,   32'h000, 0, 0);  // stall holds invalid
        add(0, 0, 0, 0, 32'h0,   32'h044, 16,  32'h044, 1, 0);
        add(0, 1, 0, 0, 32'h0,   32'h048, 17,  32'h048, 1, 0);  // start in RUN ignored
        add(0, 0, 0, 1, 32'h7C,  32'h07C, 0,   32'h000, 0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h080, 31,  32'h080, 1, 0);
        add(1, 0, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // reset mid-run
        add(0, 0, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // no fetch until start
        add(0, 0, 1, 1, 32'h40,  32'h000, 0,   32'h000, 0, 0);  // branch in idle ignored
        add(0, 1, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);
        add(0, 0, 0, 1, 32'h1FC, 32'h1FC, 0,   32'h000, 0, 0);
        add(0, 0, 0, 0, 32'h0,   32'h200, 127, 32'h200, 1, 0);  // last word
        add(0, 0, 0, 0, 32'h0,   32'h200, 127, 32'h200, 0, 1);  // halt
        add(0, 1, 0, 1, 32'h0,   32'h200, 127, 32'h200, 0, 1);  // ignored in halt
        add(0, 0, 1, 0, 32'h0,   32'h200, 127, 32'h200, 0, 1);
        add(1, 0, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);  // reset exits halt
        add(0, 1, 0, 0, 32'h0,   32'h000, 0,   32'h000, 0, 0);
        add(0, 0, 0, 1, 32'h300, 32'h300, 0,   32'h000, 0, 0);  // branch past end accepted
        add(0, 0, 0, 0, 32'h0,   32'h300, 0,   32'h000, 0, 1);  // then halts
        add(1, 1, 1, 1, 32'h40,  32'h000, 0,   32'h000, 0, 0);  // reset overrides all

        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].rst, tbl[i].st, tbl[i].sl, tbl[i].br, tbl[i].tgt);
            chk_all($sformatf("tbl%0d", i), tbl[i].e_pc, tbl[i].e_ins,
                    tbl[i].e_p4, tbl[i].e_v, tbl[i].e_h);
        end

        // Free run from 0 through the whole memory, then halt.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        chk_all("run.start", 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 128; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk_all($sformatf("run%0d", i), 32'(4 * (i + 1)), 32'(i), 32'(4 * (i + 1)), 1, 0);
        end
        cyc(0, 0, 0, 0, 0);
        chk_all("run.halt", 32'h200, 127, 32'h200, 0, 1);
        cyc(0, 1, 0, 1, 32'h10);
        chk_all("run.halt_hold", 32'h200, 127, 32'h200, 0, 1);

        // Reset mid-run: no valid pulse afterwards while idle.
        cyc(1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 0);
        for (int i = 0; i < 32; i++) cyc(0, 0, 0, 0, 0);
        chk_all("rst.pre", 32'h80, 31, 32'h80, 1, 0);
        cyc(1, 0, 0, 0, 0);
        chk_all("rst.at", 32'h0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 0);
            chk_all("rst.idle", 32'h0, 0, 0, 0, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            bit          r, s, sl, b;
            logic [31:0] t;
            r  = ($urandom_range(0, 63) == 0);
            s  = ($urandom_range(0, 3) == 0);
            sl = ($urandom_range(0, 3) == 0);
            b  = ($urandom_range(0, 9) == 0);
            t  = 32'($urandom_range(0, 32'h220));
            cyc(r, s, sl, b, t);
            chk_all("rand", m_pc, m_ins, m_p4, m_v, m_h);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
